// File: rtl/i2c_resp_pkg.sv
// Shared types for the I2C target responder: FSM states, bus levels and line events.
package i2c_resp_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdLoad,
    StRdByte,
    StRdAck,
    StWaitStop
  } i2c_resp_state_t;

  // SDA level for ACK; NACK doubles as the released (pulled-up) level.
  localparam logic AckLevel  = 1'b0;
  localparam logic NackLevel = 1'b1;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
  } line_evt_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and flags SCL edges and START/STOP.
module i2c_line_sync
  import i2c_resp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk_i,
  input  logic      scl_i,
  input  logic      sda_i,
  output logic      sda_sync_o,
  output line_evt_t evt_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // No reset: the chain always tracks the real lines, so leaving reset mid-transfer
  // cannot fabricate a START from stale history.
  always_ff @(posedge clk_i) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_q <= scl_s;
    sda_prev_q <= sda_s;
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_sync_o = sda_s;

  always_comb begin
    evt_o.scl_rise = scl_s & ~scl_prev_q;
    evt_o.scl_fall = ~scl_s & scl_prev_q;
    evt_o.start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    evt_o.stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  end

endmodule

// File: rtl/i2c_slave_responder.sv
// Synthesizable I2C target: decodes address/data, hands written bytes out and pulls read
// bytes in through a valid/ready port, stretching SCL while read data is unavailable.
module i2c_slave_responder
  import i2c_resp_pkg::*;
#(
  parameter int unsigned                   I2C_ADDR_WIDTH = 7,
  parameter int unsigned                   I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0]     SLAVE_ADDR     = 7'h22,
  parameter int unsigned                   SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  input  logic                      rd_valid_i,
  output logic                      rd_ready_o,
  output logic                      rw_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      busy_o
);

  localparam int unsigned DW = I2C_DATA_WIDTH;

  line_evt_t       evt;
  logic            sda_s;
  i2c_resp_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   shift_q, shift_d, shift_in;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            scl_q, scl_d, sda_q, sda_d;
  logic            rw_q, rw_d, busy_q, busy_d;
  logic            wr_valid_q, wr_valid_d, rd_ready_q, rd_ready_d;
  logic            start_q, start_d, stop_q, stop_d;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk_i      (clk_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_sync_o (sda_s),
    .evt_o      (evt)
  );

  assign shift_in = {shift_q[DW-2:0], sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wr_data_d  = wr_data_q;
    scl_d      = 1'b1;
    sda_d      = sda_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    rd_ready_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;

    if (evt.stop) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      sda_d   = NackLevel;
      stop_d  = 1'b1;
    end else if (evt.start) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      sda_d   = NackLevel;
      start_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (evt.scl_rise && cnt_q < 4'd8) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (shift_in[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) rw_d = shift_in[0];
              else state_d = StWaitStop;
            end
          end else if (evt.scl_fall && cnt_q == 4'd8) begin
            sda_d   = AckLevel;
            state_d = StAddrAck;
          end
        end
        StAddrAck: begin
          if (evt.scl_fall) begin
            sda_d   = NackLevel;
            cnt_d   = 4'd0;
            state_d = rw_q ? StRdLoad : StWrByte;
          end
        end
        StWrByte: begin
          if (evt.scl_rise && cnt_q < 4'd8) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              wr_data_d  = shift_in;
              wr_valid_d = 1'b1;
            end
          end else if (evt.scl_fall && cnt_q == 4'd8) begin
            sda_d   = AckLevel;
            state_d = StWrAck;
          end
        end
        StWrAck: begin
          if (evt.scl_fall) begin
            sda_d   = NackLevel;
            cnt_d   = 4'd0;
            state_d = StWrByte;
          end
        end
        StRdLoad: begin
          if (rd_valid_i) begin
            shift_d    = {rd_data_i[DW-2:0], 1'b0};
            sda_d      = rd_data_i[DW-1];
            rd_ready_d = 1'b1;
            cnt_d      = 4'd0;
            // If stretching, keep SCL low one more cycle so the MSB settles before release.
            scl_d      = scl_q;
            state_d    = StRdByte;
          end else begin
            scl_d = 1'b0;
          end
        end
        StRdByte: begin
          if (evt.scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_d   = NackLevel;
              state_d = StRdAck;
            end else begin
              sda_d   = shift_q[DW-1];
              shift_d = {shift_q[DW-2:0], 1'b0};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (evt.scl_rise && sda_s == NackLevel) state_d = StWaitStop;
          else if (evt.scl_fall) state_d = StRdLoad;
        end
        StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= '0;
      wr_data_q  <= '0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_ready_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_data_q  <= wr_data_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      rd_ready_q <= rd_ready_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_o      = scl_q;
  assign sda_o      = sda_q;
  assign wr_data_o  = wr_data_q;
  assign wr_valid_o = wr_valid_q;
  assign rd_ready_o = rd_ready_q;
  assign rw_o       = rw_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master with clock-stretch support drives the
// target; expectations come from a transaction-level model of address match, ACKs and data.
module tb_i2c_slave_responder;

  localparam int unsigned Q = 8;  // quarter SCL period in clk cycles
  localparam logic [6:0] MyAddr = 7'h22;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_line, sda_line;
  logic       scl_o, sda_o, wr_valid_o, rd_valid_i, rd_ready_o, rw_o, start_o, stop_o, busy_o;
  logic [7:0] wr_data_o, rd_data_i;

  int total = 0, bad = 0;
  int n_wr = 0, n_rd = 0, n_start = 0, n_stop = 0, n_sda_low = 0, n_scl_low = 0;
  int stretch_cnt = 0, rd_src_n = 0;
  bit stretch_mode = 1'b0;
  logic [7:0] wr_log[1024];
  logic [7:0] rd_src[1024];
  logic [7:0] wbuf[64];
  logic [7:0] rbuf[64];
  logic       abuf[65];

  always #5 clk = ~clk;

  assign scl_line   = scl_m & scl_o;
  assign sda_line   = sda_m & sda_o;
  assign rd_data_i  = rd_src[n_rd % 1024];
  assign rd_valid_i = (n_rd < rd_src_n) && (!stretch_mode || stretch_cnt >= 50);

  i2c_slave_responder dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .scl_i      (scl_line),
    .sda_i      (sda_line),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .wr_data_o  (wr_data_o),
    .wr_valid_o (wr_valid_o),
    .rd_data_i  (rd_data_i),
    .rd_valid_i (rd_valid_i),
    .rd_ready_o (rd_ready_o),
    .rw_o       (rw_o),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .busy_o     (busy_o)
  );

  always @(negedge clk) begin
    if (wr_valid_o) begin
      wr_log[n_wr % 1024] <= wr_data_o;
      n_wr <= n_wr + 1;
    end
    if (rd_ready_o) n_rd <= n_rd + 1;
    if (start_o) n_start <= n_start + 1;
    if (stop_o) n_stop <= n_stop + 1;
    if (!sda_o) n_sda_low <= n_sda_low + 1;
    if (!scl_o) n_scl_low <= n_scl_low + 1;
    stretch_cnt <= !stretch_mode ? 0 : stretch_cnt + (scl_o ? 0 : 1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl_line !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (scl_line !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL scl_release: scl line=%b, required 1 within 3000 cycles", scl_line);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "SCL held low");
    end
  endtask

  task automatic bus_start();
    scl_m = 1'b0; wait_cycles(Q);
    sda_m = 1'b1; wait_cycles(Q);
    scl_m = 1'b1; wait_scl_high(); wait_cycles(Q);
    sda_m = 1'b0; wait_cycles(Q);
    scl_m = 1'b0; wait_cycles(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_cycles(Q);
    scl_m = 1'b1; wait_scl_high(); wait_cycles(Q);
    sda_m = 1'b1; wait_cycles(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_cycles(Q);
    scl_m = 1'b1; wait_scl_high(); wait_cycles(2 * Q);
    scl_m = 1'b0; wait_cycles(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_cycles(Q);
    scl_m = 1'b1; wait_scl_high(); wait_cycles(Q);
    b = sda_line; wait_cycles(Q);
    scl_m = 1'b0; wait_cycles(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // Address phase plus n bytes from wbuf; acks land in abuf[0..n].
  task automatic run_write(input logic [6:0] addr, input int n);
    logic a;
    write_byte({addr, 1'b0}, a);
    abuf[0] = a;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a);
      abuf[i+1] = a;
    end
  endtask

  // Address phase plus n reads, the last one NACKed; data lands in rbuf.
  task automatic run_read(input logic [6:0] addr, input int n);
    logic a;
    logic [7:0] d;
    write_byte({addr, 1'b1}, a);
    abuf[0] = a;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      rbuf[i] = d;
    end
  endtask

  task automatic supply(input logic [7:0] d);
    rd_src[rd_src_n % 1024] = d;
    rd_src_n++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wait_cycles(5);
    total++;
    if ({scl_o, sda_o, wr_valid_o, rd_ready_o, rw_o, start_o, stop_o, busy_o} !== 8'b1100_0000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 11000000",
               {scl_o, sda_o, wr_valid_o, rd_ready_o, rw_o, start_o, stop_o, busy_o});
    end
    total++;
    if (wr_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_wr_data: got %h want 00", wr_data_o);
    end
    rst_i = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_write();
    int b_wr = n_wr, b_st = n_start, b_sp = n_stop, acks = 0;
    bus_start();
    for (int i = 0; i < 32; i++) wbuf[i] = 8'(i);
    run_write(MyAddr, 32);
    for (int i = 0; i <= 32; i++) if (abuf[i] == 1'b0) acks++;
    total++;
    if (rw_o !== 1'b0) begin bad++; $display("FAIL write_rw: got %b want 0", rw_o); end
    bus_stop();
    total++;
    if (acks != 33) begin bad++; $display("FAIL write_acks: got %0d want 33", acks); end
    total++;
    if (n_wr - b_wr != 32) begin bad++; $display("FAIL write_count: got %0d want 32", n_wr - b_wr); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (wr_log[(b_wr + i) % 1024] !== 8'(i)) begin
        bad++;
        $display("FAIL write_data[%0d]: got %h want %h", i, wr_log[(b_wr + i) % 1024], 8'(i));
      end
    end
    total++;
    if (n_start - b_st != 1 || n_stop - b_sp != 1) begin
      bad++;
      $display("FAIL write_start_stop: got %0d/%0d want 1/1", n_start - b_st, n_stop - b_sp);
    end
  endtask

  task automatic test_read();
    int b_rd = n_rd, b_low;
    logic [7:0] d;
    for (int i = 0; i < 32; i++) supply(8'(100 + i));
    bus_start();
    run_read(MyAddr, 32);
    total++;
    if (abuf[0] !== 1'b0) begin bad++; $display("FAIL read_addr_ack: got %b want 0", abuf[0]); end
    total++;
    if (rw_o !== 1'b1) begin bad++; $display("FAIL read_rw: got %b want 1", rw_o); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (rbuf[i] !== 8'(100 + i)) begin
        bad++;
        $display("FAIL read_data[%0d]: got %0d want %0d", i, rbuf[i], 100 + i);
      end
    end
    // After the NACK the target must ignore further clocks and keep SDA released.
    b_low = n_sda_low;
    read_byte(1'b1, d);
    total++;
    if (d !== 8'hFF || n_sda_low != b_low) begin
      bad++;
      $display("FAIL read_after_nack: got %h low=%0d want ff low=0", d, n_sda_low - b_low);
    end
    bus_stop();
    total++;
    if (n_rd - b_rd != 32) begin bad++; $display("FAIL read_count: got %0d want 32", n_rd - b_rd); end
  endtask

  task automatic test_addr_miss();
    int b_wr = n_wr, b_rd = n_rd, b_low = n_sda_low;
    logic [6:0] other;
    bus_start();
    wbuf[0] = 8'($urandom);
    run_write(7'h23, 1);
    bus_stop();
    total++;
    if (abuf[0] !== 1'b1 || abuf[1] !== 1'b1) begin
      bad++;
      $display("FAIL miss_nak: got %b%b want 11", abuf[0], abuf[1]);
    end
    other = 7'($urandom);
    if (other == MyAddr) other = other ^ 7'h01;
    supply(8'($urandom));
    bus_start();
    run_read(other, 1);
    bus_stop();
    rd_src_n = n_rd;
    total++;
    if (abuf[0] !== 1'b1 || rbuf[0] !== 8'hFF) begin
      bad++;
      $display("FAIL miss_read: got ack=%b data=%h want 1/ff", abuf[0], rbuf[0]);
    end
    total++;
    if (n_sda_low != b_low || n_wr != b_wr || n_rd != b_rd) begin
      bad++;
      $display("FAIL miss_quiet: got sda_low=%0d wr=%0d rd=%0d want 0/0/0",
               n_sda_low - b_low, n_wr - b_wr, n_rd - b_rd);
    end
  endtask

  task automatic test_stretch();
    int b_rd = n_rd, b_low = n_scl_low;
    stretch_mode = 1'b1;
    supply(8'hA5);
    bus_start();
    run_read(MyAddr, 1);
    bus_stop();
    stretch_mode = 1'b0;
    total++;
    if (rbuf[0] !== 8'hA5) begin bad++; $display("FAIL stretch_data: got %h want a5", rbuf[0]); end
    total++;
    if (n_rd - b_rd != 1) begin bad++; $display("FAIL stretch_ready: got %0d want 1", n_rd - b_rd); end
    total++;
    if (n_scl_low - b_low < 50 || n_scl_low - b_low > 52) begin
      bad++;
      $display("FAIL stretch_len: got %0d want 50..52", n_scl_low - b_low);
    end
  endtask

  task automatic test_repeated_start();
    int b_wr = n_wr, b_st = n_start, b_sp = n_stop;
    logic [7:0] rd = 8'($urandom);
    logic rw_w, rw_r;
    bus_start();
    wbuf[0] = 8'h12;
    run_write(MyAddr, 1);
    rw_w = rw_o;
    supply(rd);
    bus_start();
    run_read(MyAddr, 1);
    rw_r = rw_o;
    bus_stop();
    total++;
    if (n_wr - b_wr != 1 || wr_log[b_wr % 1024] !== 8'h12) begin
      bad++;
      $display("FAIL rs_write: got n=%0d data=%h want 1/12", n_wr - b_wr, wr_log[b_wr % 1024]);
    end
    total++;
    if (rw_w !== 1'b0 || rw_r !== 1'b1) begin
      bad++;
      $display("FAIL rs_rw: got %b->%b want 0->1", rw_w, rw_r);
    end
    total++;
    if (n_start - b_st != 2 || n_stop - b_sp != 1) begin
      bad++;
      $display("FAIL rs_start_stop: got %0d/%0d want 2/1", n_start - b_st, n_stop - b_sp);
    end
    total++;
    if (rbuf[0] !== rd) begin bad++; $display("FAIL rs_read: got %h want %h", rbuf[0], rd); end
  endtask

  task automatic test_reset_mid();
    int b_wr = n_wr;
    logic a;
    logic [7:0] d = 8'($urandom);
    bus_start();
    write_byte({MyAddr, 1'b0}, a);
    for (int i = 7; i >= 4; i--) send_bit(d[i]);
    rst_i = 1'b1;
    @(negedge clk);
    total++;
    if ({scl_o, sda_o, wr_valid_o, rd_ready_o, rw_o, start_o, stop_o, busy_o} !== 8'b1100_0000
        || wr_data_o !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b/%h want 11000000/00",
               {scl_o, sda_o, wr_valid_o, rd_ready_o, rw_o, start_o, stop_o, busy_o}, wr_data_o);
    end
    rst_i = 1'b0;
    wait_cycles(4 * Q);
    total++;
    if (n_wr != b_wr) begin bad++; $display("FAIL mid_no_write: got %0d want 0", n_wr - b_wr); end
    wbuf[0] = 8'($urandom);
    bus_start();
    run_write(MyAddr, 1);
    bus_stop();
    total++;
    if (abuf[0] !== 1'b0 || abuf[1] !== 1'b0 || n_wr - b_wr != 1
        || wr_log[b_wr % 1024] !== wbuf[0]) begin
      bad++;
      $display("FAIL mid_recover: got acks=%b%b n=%0d data=%h want 00/1/%h",
               abuf[0], abuf[1], n_wr - b_wr, wr_log[b_wr % 1024], wbuf[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rd[64];
    for (int t = 0; t < 6; t++) begin
      bit hit = 1'($urandom_range(0, 1));
      bit rw = 1'($urandom_range(0, 1));
      int n = int'($urandom_range(1, 4));
      int b_wr = n_wr, b_rd = n_rd;
      logic [6:0] addr = hit ? MyAddr : 7'($urandom);
      logic exp_ack;
      if (!hit && addr == MyAddr) addr = addr ^ 7'h40;
      exp_ack = hit ? 1'b0 : 1'b1;
      bus_start();
      if (!rw) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        run_write(addr, n);
        for (int i = 0; i <= n; i++) begin
          total++;
          if (abuf[i] !== exp_ack) begin
            bad++;
            $display("FAIL b2b_wack[%0d.%0d]: got %b want %b", t, i, abuf[i], exp_ack);
          end
        end
        total++;
        if (n_wr - b_wr != (hit ? n : 0)) begin
          bad++;
          $display("FAIL b2b_wcount[%0d]: got %0d want %0d", t, n_wr - b_wr, hit ? n : 0);
        end
        for (int i = 0; i < n && hit; i++) begin
          total++;
          if (wr_log[(b_wr + i) % 1024] !== wbuf[i]) begin
            bad++;
            $display("FAIL b2b_wdata[%0d.%0d]: got %h want %h", t, i,
                     wr_log[(b_wr + i) % 1024], wbuf[i]);
          end
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          exp_rd[i] = 8'($urandom);
          supply(exp_rd[i]);
        end
        run_read(addr, n);
        total++;
        if (abuf[0] !== exp_ack) begin
          bad++;
          $display("FAIL b2b_rack[%0d]: got %b want %b", t, abuf[0], exp_ack);
        end
        for (int i = 0; i < n; i++) begin
          total++;
          if (rbuf[i] !== (hit ? exp_rd[i] : 8'hFF)) begin
            bad++;
            $display("FAIL b2b_rdata[%0d.%0d]: got %h want %h", t, i, rbuf[i],
                     hit ? exp_rd[i] : 8'hFF);
          end
        end
        total++;
        if (n_rd - b_rd != (hit ? n : 0)) begin
          bad++;
          $display("FAIL b2b_rcount[%0d]: got %0d want %0d", t, n_rd - b_rd, hit ? n : 0);
        end
        rd_src_n = n_rd;
      end
      if (t == 5 || $urandom_range(0, 1) == 0) bus_stop();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_miss();
    test_stretch();
    test_repeated_start();
    test_reset_mid();
    test_back_to_back();
    wait_cycles(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
Synthesizable I2C target that answers the iicmb_m_wb bus master on one I2C bus, replacing the behavioural i2c_if slave in RTL-level and system benches.
- Oversamples SCL/SDA on the system clock.
- Decodes START, STOP, address and data.
- Delivers written bytes on a valid-pulse output and pulls read bytes from a valid/ready input.
- Stretches SCL while read data is unavailable.

Parameters:
I2C_ADDR_WIDTH, 7, target address width
I2C_DATA_WIDTH, 8, byte width
SLAVE_ADDR, 7'h22, address this target responds to
SYNC_STAGES, 2, flip-flop synchronizer depth on scl_i/sda_i (minimum 2)

Ports:
clk_i  in  1  system clock; must be at least 16x the SCL rate
rst_i  in  1  synchronous, active-high reset
scl_i  in  1  I2C clock line sense
sda_i  in  1  I2C data line sense
scl_o  out  1  open-drain SCL drive; 0 = pull low, 1 = release
sda_o  out  1  open-drain SDA drive; 0 = pull low, 1 = release
wr_data_o  out  I2C_DATA_WIDTH  last byte written by the master
wr_valid_o  out  1  one-cycle pulse when wr_data_o updates
rd_data_i  in  I2C_DATA_WIDTH  next byte to return to the master
rd_valid_i  in  1  rd_data_i is available
rd_ready_o  out  1  one-cycle pulse when rd_data_i is consumed
rw_o  out  1  direction of the current transfer; 1 = read
start_o  out  1  one-cycle pulse on START or repeated START addressed to any target
stop_o  out  1  one-cycle pulse on STOP
busy_o  out  1  high from START until STOP

Behaviour:
- Reset values: scl_o=1, sda_o=1, wr_data_o=0, wr_valid_o=0, rd_ready_o=0, rw_o=0, start_o=0, stop_o=0, busy_o=0; state=IDLE.
- rst_i asserted mid-transfer applies the reset values on the next edge. Both lines are released immediately. The bus is re-acquired only at the next START.
- Line conditioning:
  - SYNC_STAGES-flop synchronizers feed registered copies.
  - scl_rise, scl_fall and sda edges are detected between the synchronized value and the previous sample.
- Bus conditions:
  - START = SDA falling while SCL is high.
  - STOP = SDA rising while SCL is high.
  - In the same clk_i cycle, START/STOP take priority over any SCL edge.
- Sampling and driving:
  - Bits are sampled on scl_rise.
  - sda_o changes only in the cycle after scl_fall, never while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE: START -> ADDR, bit counter=0, start_o pulse, busy_o=1.
- ADDR: shifts in 8 bits, MSB first.
  - On the 8th scl_rise, the upper 7 bits are compared with SLAVE_ADDR.
  - Match: rw_o=bit0; on the next scl_fall drive sda_o=0 -> ADDR_ACK.
  - Mismatch: -> WAIT_STOP; sda_o stays 1.
- ADDR_ACK: on scl_fall, release SDA.
  - rw_o=0 -> WR_BYTE.
  - rw_o=1 -> RD_LOAD.
- WR_BYTE: shifts in 8 bits.
  - On the 8th scl_rise: wr_data_o updates, wr_valid_o pulses the following cycle.
  - On the next scl_fall drive ACK (sda_o=0) -> WR_ACK.
  - Every written byte is ACKed.
- WR_ACK: on scl_fall, release SDA -> WR_BYTE.
- RD_LOAD (entered on scl_fall, with SCL low):
  - rd_valid_i=1: latch rd_data_i into the shift register, pulse rd_ready_o, drive MSB on sda_o, scl_o=1 -> RD_BYTE.
  - rd_valid_i=0: hold scl_o=0 (stretch) until rd_valid_i=1. No timeout.
- RD_BYTE: on each scl_fall, shift out the next bit.
  - After the 8th bit's scl_fall, release SDA -> RD_ACK.
- RD_ACK: sample the master's bit on scl_rise.
  - 0 (ACK): on scl_fall -> RD_LOAD.
  - 1 (NACK): -> WAIT_STOP with SDA released.
- WAIT_STOP: drives nothing; waits for STOP or repeated START.
- Repeated START in any non-IDLE state -> ADDR, counter cleared, start_o pulse, both lines released.
- STOP in any state -> IDLE, stop_o pulse, busy_o=0, lines released.
  - A partial write byte is discarded with no wr_valid_o pulse.
- rd_valid_i is ignored outside RD_LOAD. rd_ready_o never pulses without a byte being latched.
- Bit counter: 4 bits, 0..8, cleared on every state change into a byte state. No wrap.

Decomposition:
- Package i2c_resp_pkg:
  - state enum i2c_resp_state_t
  - localparams for the ACK/NACK levels
  - line-event typedef {scl_rise, scl_fall, start, stop}
- Sub-module i2c_line_sync: synchronizers, edge detection, START/STOP detection, parameterised by SYNC_STAGES.
- The FSM, shift registers and user interface stay in i2c_slave_responder.

Test Plan:
- Write path: iicmb writes 0x44 then bytes 0x00..0x1F, then STOP. Required: 33 ACKs; 32 wr_valid_o pulses with wr_data_o=0..31 in order; rw_o=0; one start_o pulse and one stop_o pulse.
- Read path: iicmb writes 0x45 and performs 31 read-with-ACK plus 1 read-with-NACK; rd_data_i supplies 100..131 with rd_valid_i held high. Required: DPR reads return 100..131; 32 rd_ready_o pulses; WAIT_STOP entered after the NACK; SDA released.
- Address miss: master sends 0x46 (address 0x23). Required: sda_o stays 1 throughout; NAK reported by iicmb CMDR; no wr_valid_o or rd_ready_o pulses.
- Clock stretch: on a read, rd_valid_i is held low for 50 clk_i cycles after the ACK. Required: scl_o=0 for those 50 cycles; byte 0xA5 then shifted correctly; exactly one rd_ready_o pulse.
- Repeated START: write 0x44, data 0x12, then repeated START to 0x45 and read one byte with NACK. Required: wr_valid_o with data 0x12; two start_o pulses; rw_o flips 0->1; one stop_o pulse.
- Reset mid-byte: rst_i pulsed after 4 data bits of a write. Required: all outputs at reset values on the next edge; no wr_valid_o pulse; the next START/address 0x44 transfer completes normally.
